clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable 50%-duty clock divider with clean start/stop
// and a ready/valid port for changing the half-period terminal count.
// Optional feature: define CLK_DIV_CTRL_CNT_EN to add the 16-bit edge_cnt
// output, which counts tick pulses since reset.
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_MAX = 2200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_max,
  output logic             cfg_ready,
  output logic             sclk,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_max
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_cur_max, w_cur_max_d;
  logic [WIDTH-1:0] r_pend, w_pend_d;
  logic             r_pend_vld, w_pend_vld_d;
  logic             r_sclk, w_sclk_d;
  logic             r_tick, w_tick_d;

  logic             w_active;
  logic             w_boundary;
  logic             w_accept;
  logic             w_toggle;

  assign w_active   = (r_state != StIdle);
  assign w_boundary = w_active && (r_cnt == r_cur_max);
  assign w_accept   = cfg_valid && !r_pend_vld;
  // STOPPING with run reasserted behaves exactly like RUN, so the phase is kept.
  assign w_toggle   = w_boundary && ((r_state == StRun) || (r_state == StStopping && run));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (run) w_state_d = StRun;
      end
      StRun: begin
        if (!run) w_state_d = StStopping;
      end
      StStopping: begin
        if (run) begin
          w_state_d = StRun;
        end else if (w_boundary) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath next values: counter, sclk phase, tick, and terminal-count handoff
  always_comb begin
    w_cnt_d      = '0;
    w_sclk_d     = 1'b0;
    w_tick_d     = 1'b0;
    w_cur_max_d  = r_cur_max;
    w_pend_d     = r_pend;
    w_pend_vld_d = r_pend_vld;

    if (w_active) begin
      w_cnt_d  = w_boundary ? '0 : r_cnt + 1'b1;
      w_sclk_d = r_sclk;
      if (w_toggle) begin
        w_sclk_d = ~r_sclk;
        w_tick_d = ~r_sclk;
      end else if (w_boundary) begin
        // Stopping at a boundary: a finished high phase falls, a low phase stays low.
        w_sclk_d = 1'b0;
      end
    end

    // cur_max only changes between half periods (or while idle), so no
    // half period in progress is ever shortened.
    if (r_pend_vld && (!w_active || w_boundary)) begin
      w_cur_max_d  = r_pend;
      w_pend_vld_d = 1'b0;
    end else if (w_accept) begin
      w_pend_d     = cfg_max;
      w_pend_vld_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sclk     <= 1'b0;
      r_tick     <= 1'b0;
      r_cur_max  <= WIDTH'(DEFAULT_MAX);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_sclk     <= w_sclk_d;
      r_tick     <= w_tick_d;
      r_cur_max  <= w_cur_max_d;
      r_pend     <= w_pend_d;
      r_pend_vld <= w_pend_vld_d;
    end
  end

  // Outputs
  always_comb begin
    busy      = w_active;
    cfg_ready = !r_pend_vld;
    sclk      = r_sclk;
    tick      = r_tick;
    cur_max   = r_cur_max;
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] r_edge_cnt;

  // Tick counter, advanced on the same edge that raises tick; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
    end else if (w_tick_d) begin
      r_edge_cnt <= r_edge_cnt + 16'd1;
    end
  end

  assign edge_cnt = r_edge_cnt;
`endif

endmodule
